// File: rtl/output_backprop.sv
// Output-layer weight update for a two-input linear neuron: err, gradients,
// learning-rate step and saturating write-back of both weights.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   start_i             request one pass (taken only in IDLE)
//   target_i            unsigned integer target
//   predicted_i         forward-pass sum of x*w, FRAC_W fraction bits
//   x0_i, x1_i          unsigned integer activations
//   w0_i, w1_i          current weights, unsigned 1.FRAC_W
//   lr_shift_i          learning rate as a right-shift amount
//   busy_o, done_o      pass in progress / one-cycle result strobe
//   w0_o, w1_o          updated weights (registered)
//   err_o               signed error of the last pass (registered)
//   sat_o               a weight clipped in the last pass
module output_backprop #(
    parameter int FRAC_W = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  target_i,
    input  logic [20:0] predicted_i,
    input  logic [9:0]  x0_i,
    input  logic [9:0]  x1_i,
    input  logic [7:0]  w0_i,
    input  logic [7:0]  w1_i,
    input  logic [3:0]  lr_shift_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  w0_o,
    output logic [7:0]  w1_o,
    output logic [21:0] err_o,
    output logic        sat_o
);

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        G0,
        U0,
        G1,
        U1,
        DONE
    } state_t;

    localparam logic [4:0] FRAC_SH = 5'(FRAC_W);

    state_t state;

    // Operands captured when a pass is accepted
    logic [3:0]  tgt_q;
    logic [20:0] pred_q;
    logic [9:0]  x0_q;
    logic [9:0]  x1_q;
    logic [7:0]  w0_q;
    logic [7:0]  w1_q;
    logic [3:0]  lr_q;

    // Pipeline of intermediate results
    logic signed [21:0] err_q;
    logic signed [32:0] grad_q;
    logic [7:0]         nw0_q;
    logic               sat0_q;

    // Error: prediction minus target aligned to the prediction's fraction
    logic [21:0]        tgt_scaled;
    logic signed [21:0] err_calc;

    assign tgt_scaled = 22'(tgt_q) << FRAC_W;
    assign err_calc   = $signed(22'(pred_q) - tgt_scaled);

    // Single multiplier, operand chosen by the gradient state in flight
    logic [9:0]         x_sel;
    logic signed [10:0] mul_op;
    logic signed [32:0] prod;

    assign x_sel  = (state == G1) ? x1_q : x0_q;
    assign mul_op = $signed({1'b0, x_sel});
    assign prod   = 33'(err_q) * 33'(mul_op);

    // The gradient still carries the error's fraction bits, so the
    // step is scaled down by FRAC_W on top of the learning-rate shift.
    logic [4:0]         shamt;
    logic signed [32:0] step;
    logic [7:0]         w_cur;
    logic signed [33:0] w_new;

    assign shamt = 5'(lr_q) + FRAC_SH;
    assign step  = grad_q >>> shamt;
    assign w_cur = (state == U1) ? w1_q : w0_q;
    assign w_new = $signed({26'd0, w_cur}) - 34'(step);

    // Clamp to the unsigned weight range and flag any clip
    logic [7:0] w_sat;
    logic       clip;

    always_comb begin
        w_sat = w_new[7:0];
        clip  = 1'b0;
        if (w_new < 34'sd0) begin
            w_sat = 8'd0;
            clip  = 1'b1;
        end else if (w_new > 34'sd255) begin
            w_sat = 8'd255;
            clip  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            tgt_q  <= '0;
            pred_q <= '0;
            x0_q   <= '0;
            x1_q   <= '0;
            w0_q   <= '0;
            w1_q   <= '0;
            lr_q   <= '0;
            err_q  <= '0;
            grad_q <= '0;
            nw0_q  <= '0;
            sat0_q <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            w0_o   <= '0;
            w1_o   <= '0;
            err_o  <= '0;
            sat_o  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        tgt_q  <= target_i;
                        pred_q <= predicted_i;
                        x0_q   <= x0_i;
                        x1_q   <= x1_i;
                        w0_q   <= w0_i;
                        w1_q   <= w1_i;
                        lr_q   <= lr_shift_i;
                        busy_o <= 1'b1;
                        state  <= ERR;
                    end
                end
                ERR: begin
                    err_q <= err_calc;
                    state <= G0;
                end
                G0: begin
                    grad_q <= prod;
                    state  <= U0;
                end
                U0: begin
                    nw0_q  <= w_sat;
                    sat0_q <= clip;
                    state  <= G1;
                end
                G1: begin
                    grad_q <= prod;
                    state  <= U1;
                end
                U1: begin
                    w0_o   <= nw0_q;
                    w1_o   <= w_sat;
                    err_o  <= err_q;
                    sat_o  <= sat0_q | clip;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_backprop.sv
// Directed-vector bench for output_backprop: weight-update results,
// handshake timing, start filtering and mid-pass reset.
module tb_output_backprop;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  target_i;
    logic [20:0] predicted_i;
    logic [9:0]  x0_i;
    logic [9:0]  x1_i;
    logic [7:0]  w0_i;
    logic [7:0]  w1_i;
    logic [3:0]  lr_shift_i;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  w0_o;
    logic [7:0]  w1_o;
    logic [21:0] err_o;
    logic        sat_o;

    output_backprop #(.FRAC_W(7)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .target_i    (target_i),
        .predicted_i (predicted_i),
        .x0_i        (x0_i),
        .x1_i        (x1_i),
        .w0_i        (w0_i),
        .w1_i        (w1_i),
        .lr_shift_i  (lr_shift_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .w0_o        (w0_o),
        .w1_o        (w1_o),
        .err_o       (err_o),
        .sat_o       (sat_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [20:0] pred;
        logic [3:0]  tgt;
        logic [9:0]  x0;
        logic [9:0]  x1;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [3:0]  lr;
        int          err;
        logic [7:0]  ew0;
        logic [7:0]  ew1;
        logic        es;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        predicted_i = v.pred;
        target_i    = v.tgt;
        x0_i        = v.x0;
        x1_i        = v.x1;
        w0_i        = v.w0;
        w1_i        = v.w1;
        lr_shift_i  = v.lr;
    endtask

    task automatic scramble();
        predicted_i = 21'($urandom);
        target_i    = 4'($urandom);
        x0_i        = 10'($urandom);
        x1_i        = 10'($urandom);
        w0_i        = 8'($urandom);
        w1_i        = 8'($urandom);
        lr_shift_i  = 4'($urandom);
    endtask

    task automatic chk_out(string name, vec_t v);
        logic [21:0] e;
        e = 22'(v.err);
        chk({name, ".err"}, 64'(err_o), 64'(e));
        chk({name, ".w0"}, 64'(w0_o), 64'(v.ew0));
        chk({name, ".w1"}, 64'(w1_o), 64'(v.ew1));
        chk({name, ".sat"}, 64'(sat_o), 64'(v.es));
    endtask

    // One pass: inputs change right after acceptance to prove capture
    task automatic run_pass(vec_t v, string name);
        logic [7:0] bb;
        logic [7:0] db;
        bb = '0;
        db = '0;
        @(negedge clk_i);
        drive(v);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        scramble();
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk_i);
            bb[i] = busy_o;
            db[i] = done_o;
            if (i == 6) chk_out(name, v);
        end
        chk({name, ".busy"}, 64'(bb), 64'(8'b0011_1110));
        chk({name, ".done"}, 64'(db), 64'(8'b0100_0000));
        chk_out({name, ".hold"}, v);
    endtask

    vec_t vt [8];

    initial begin
        logic [20:0] bbits;
        logic [20:0] dbits;
        int          ndone;

        vt[0] = '{21'd640, 4'd5, 10'd4, 10'd2, 8'd128, 8'd64, 4'd0,
                  0, 8'd128, 8'd64, 1'b0};
        vt[1] = '{21'd640, 4'd4, 10'd4, 10'd2, 8'd128, 8'd64, 4'd0,
                  128, 8'd124, 8'd62, 1'b0};
        vt[2] = '{21'd640, 4'd15, 10'd1, 10'd10, 8'd128, 8'd250, 4'd0,
                  -1280, 8'd138, 8'd255, 1'b1};
        vt[3] = '{21'd640, 4'd4, 10'd1000, 10'd0, 8'd2, 8'd100, 4'd0,
                  128, 8'd0, 8'd100, 1'b1};
        vt[4] = '{21'd640, 4'd4, 10'd1000, 10'd0, 8'd2, 8'd100, 4'd3,
                  128, 8'd0, 8'd100, 1'b1};
        vt[5] = '{21'd640, 4'd4, 10'd4, 10'd2, 8'd128, 8'd64, 4'd2,
                  128, 8'd127, 8'd64, 1'b0};
        vt[6] = '{21'd127, 4'd1, 10'd1, 10'd1000, 8'd50, 8'd10, 4'd0,
                  -1, 8'd51, 8'd18, 1'b0};
        vt[7] = '{21'd2097151, 4'd0, 10'd1023, 10'd0, 8'd255, 8'd7,
                  4'd15, 2097151, 8'd0, 8'd7, 1'b1};

        rst_i   = 1'b0;
        start_i = 1'b0;
        scramble();
        repeat (3) @(negedge clk_i);
        chk("reset", 64'({busy_o, done_o, w0_o, w1_o, err_o, sat_o}),
            64'd0);
        rst_i = 1'b1;

        for (int k = 0; k < 8; k++) begin
            run_pass(vt[k], $sformatf("vec%0d", k));
        end

        // start held for 10 cycles: one pass, then a second taken in
        // the IDLE cycle right after DONE
        bbits = '0;
        dbits = '0;
        @(negedge clk_i);
        drive(vt[1]);
        start_i = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_i);
            if (i == 10) begin
                #1;
                start_i = 1'b0;
            end
            @(negedge clk_i);
            bbits[i] = busy_o;
            dbits[i] = done_o;
        end
        chk("hold.busy", 64'(bbits), 64'(21'h001F3E));
        chk("hold.done", 64'(dbits), 64'(21'h002040));
        chk_out("hold.res", vt[1]);

        // reset during G1 of a pass that follows a non-zero result
        run_pass(vt[2], "pre_rst");
        @(negedge clk_i);
        drive(vt[1]);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrst", 64'({busy_o, done_o, w0_o, w1_o, err_o, sat_o}),
            64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (done_o) ndone++;
        end
        chk("midrst.nodone", 64'(ndone), 64'd0);
        chk("midrst.w", 64'({w0_o, w1_o, err_o, busy_o}), 64'd0);
        run_pass(vt[1], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
